// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipe_ctrl_if                                                  |
// | Purpose  : Pipeline bus between the CPU datapath and pipe_ctrl. The EX   |
// |            and WB stage indications flow into the controller; the fetch |
// |            address, fetch/flush strobes and forwarding selects flow out. |
// | Modports : master - datapath side (drives EX/WB info, uses controls)     |
// |            slave  - pipe_ctrl side (consumes EX/WB info, drives controls)|
// | Signals  : pc_f[PC_W]         fetch address (registered in pipe_ctrl)   |
// |            fetch_en           capture fetched word into EX register     |
// |            flush_ex           EX instruction is a bubble                |
// |            fwd_a, fwd_b       select WB data for operand A / B          |
// |            branch_taken_ex    EX instruction redirects fetch            |
// |            branch_target_ex   redirect address                          |
// |            halt_ex            EX instruction is ebreak                  |
// |            rs1_ex, rs2_ex     EX source register indices                |
// |            rd_wb, regwrite_wb WB destination index and write enable     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface pipe_ctrl_if #(
   parameter int PC_W = 12
);
   logic [PC_W-1:0] pc_f;
   logic            fetch_en;
   logic            flush_ex;
   logic            fwd_a;
   logic            fwd_b;
   logic            branch_taken_ex;
   logic [PC_W-1:0] branch_target_ex;
   logic            halt_ex;
   logic [4:0]      rs1_ex;
   logic [4:0]      rs2_ex;
   logic [4:0]      rd_wb;
   logic            regwrite_wb;

   modport master (
      input  pc_f, fetch_en, flush_ex, fwd_a, fwd_b,
      output branch_taken_ex, branch_target_ex, halt_ex,
      output rs1_ex, rs2_ex, rd_wb, regwrite_wb
   );

   modport slave (
      output pc_f, fetch_en, flush_ex, fwd_a, fwd_b,
      input  branch_taken_ex, branch_target_ex, halt_ex,
      input  rs1_ex, rs2_ex, rd_wb, regwrite_wb
   );
endinterface
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipe_ctrl                                                     |
// | Purpose  : Two-stage (fetch / execute) pipeline controller: run/halt     |
// |            state machine, fetch address generation, branch redirect     |
// |            with one-bubble squash, ebreak halt, WB->EX forwarding        |
// |            selects and retired-instruction counter.                      |
// | Ports    : clk          clock, rising edge                               |
// |            rst_n        asynchronous active-low reset                    |
// |            run          level run enable; 0->1 edge resumes from HALT    |
// |            clear        synchronous restart to IDLE at RESET_PC          |
// |            step_req     single-step request (used only with the macro)   |
// |            bus          pipe_ctrl_if.slave pipeline bus                  |
// |            state        IDLE=0, RUN=1, HALT=2, STEP=3                    |
// |            retired_cnt  32-bit retired instruction count                 |
// | Options  : PIPE_CTRL_SINGLE_STEP_EN - when defined, step_req in HALT     |
// |            runs one fetch cycle and one execute cycle, then HALT.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pipe_ctrl #(
   parameter int              PC_W     = 12,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   input  wire logic        run,
   input  wire logic        clear,
   input  wire logic        step_req,
   pipe_ctrl_if.slave       bus,
   output logic [1:0]       state,
   output logic [31:0]      retired_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2,
      S_STEP = 2'd3
   } state_t;

   state_t          r_state;
   logic [PC_W-1:0] r_pc;
   logic            r_ex_valid;
   logic            r_run_q;
   logic [31:0]     r_retired;

   logic            w_fetch_en;
   logic            w_redirect;
   logic            w_halt;
   logic            w_resume;
   logic [PC_W-1:0] w_pc_inc;

`ifdef PIPE_CTRL_SINGLE_STEP_EN
   // 0: STEP fetch cycle, 1: STEP execute cycle
   logic            r_step_exec;
`else
   logic            w_unused_step;
   assign w_unused_step = step_req;
`endif

   // Branch and halt indications only matter for a real instruction in EX.
   assign w_redirect = r_ex_valid & bus.branch_taken_ex;
   assign w_halt     = r_ex_valid & bus.halt_ex;
   assign w_resume   = run & ~r_run_q;
   assign w_pc_inc   = r_pc + 1'b1;

   always_comb begin
      w_fetch_en = 1'b0;
      case (r_state)
         S_RUN:   w_fetch_en = 1'b1;
`ifdef PIPE_CTRL_SINGLE_STEP_EN
         S_STEP:  w_fetch_en = ~r_step_exec;
`endif
         default: w_fetch_en = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_pc        <= RESET_PC;
         r_ex_valid  <= 1'b0;
         r_run_q     <= 1'b0;
         r_retired   <= 32'd0;
`ifdef PIPE_CTRL_SINGLE_STEP_EN
         r_step_exec <= 1'b0;
`endif
      end else begin
         r_run_q <= run;

         // An ebreak never counts as retired; a taken branch does.
         if (r_ex_valid && !w_halt) begin
            r_retired <= r_retired + 32'd1;
         end

         if (clear) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_ex_valid  <= 1'b0;
`ifdef PIPE_CTRL_SINGLE_STEP_EN
            r_step_exec <= 1'b0;
`endif
         end else begin
            // The word fetched alongside a redirect or halt is the wrong path.
            r_ex_valid <= w_fetch_en & ~w_redirect & ~w_halt;

            case (r_state)
               S_IDLE: begin
                  if (run) begin
                     r_state <= S_RUN;
                  end
               end

               S_RUN: begin
                  if (w_halt) begin
                     // pc_f already points past the ebreak; hold it there.
                     r_state <= S_HALT;
                  end else begin
                     if (w_redirect) begin
                        r_pc <= bus.branch_target_ex;
                     end else if (run) begin
                        r_pc <= w_pc_inc;
                     end
                     if (!run) begin
                        r_state <= S_HALT;
                     end
                  end
               end

               S_HALT: begin
                  // An instruction still in EX completes, including a branch.
                  if (w_redirect && !w_halt) begin
                     r_pc <= bus.branch_target_ex;
                  end
                  if (w_resume) begin
                     r_state <= S_RUN;
                  end
`ifdef PIPE_CTRL_SINGLE_STEP_EN
                  else if (step_req) begin
                     r_state     <= S_STEP;
                     r_step_exec <= 1'b0;
                  end
`endif
               end

`ifdef PIPE_CTRL_SINGLE_STEP_EN
               S_STEP: begin
                  if (!r_step_exec) begin
                     if (w_halt) begin
                        r_state <= S_HALT;
                     end else begin
                        r_pc        <= w_redirect ? bus.branch_target_ex : w_pc_inc;
                        r_step_exec <= 1'b1;
                     end
                  end else begin
                     if (w_redirect && !w_halt) begin
                        r_pc <= bus.branch_target_ex;
                     end
                     r_state     <= S_HALT;
                     r_step_exec <= 1'b0;
                  end
               end
`endif

               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.pc_f     = r_pc;
   assign bus.fetch_en = w_fetch_en;
   assign bus.flush_ex = ~r_ex_valid;
   assign bus.fwd_a    = bus.regwrite_wb & (bus.rd_wb != 5'd0) & (bus.rd_wb == bus.rs1_ex);
   assign bus.fwd_b    = bus.regwrite_wb & (bus.rd_wb != 5'd0) & (bus.rd_wb == bus.rs2_ex);

   assign state       = r_state;
   assign retired_cnt = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pipe_ctrl                                                  |
// | Purpose  : Directed self-checking bench for pipe_ctrl: reset, start-up,  |
// |            redirect bubble, halt priority and resume edge, forwarding,  |
// |            pc wrap, run-drop stop, clear, single step (or its absence)  |
// |            and asynchronous reset during a redirect.                     |
// | Options  : PIPE_CTRL_SINGLE_STEP_EN selects the single-step checks.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic        clear;
   logic        step_req;
   logic [1:0]  state;
   logic [31:0] retired_cnt;

   int errors = 0;
   int checks = 0;

   pipe_ctrl_if #(.PC_W(12)) bus ();

   pipe_ctrl #(
      .PC_W     (12),
      .RESET_PC (12'h000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .clear       (clear),
      .step_req    (step_req),
      .bus         (bus),
      .state       (state),
      .retired_cnt (retired_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      run      = 1'b0;
      clear    = 1'b0;
      step_req = 1'b0;
      bus.branch_taken_ex  = 1'b0;
      bus.branch_target_ex = 12'h000;
      bus.halt_ex          = 1'b0;
      bus.rs1_ex           = 5'd0;
      bus.rs2_ex           = 5'd0;
      bus.rd_wb            = 5'd0;
      bus.regwrite_wb      = 1'b0;

      // Reset values, visible before any clock edge
      #2;
      chk("rst_state",    32'(state), 32'd0);
      chk("rst_pc",       32'(bus.pc_f), 32'h000);
      chk("rst_flush",    32'(bus.flush_ex), 32'd1);
      chk("rst_fetch_en", 32'(bus.fetch_en), 32'd0);
      chk("rst_retired",  retired_cnt, 32'd0);

      tick(2);
      rst_n = 1'b1;
      tick(1);
      chk("idle_state", 32'(state), 32'd0);
      chk("idle_pc",    32'(bus.pc_f), 32'h000);

      // Start-up
      run = 1'b1;
      tick(1);
      chk("start_state",    32'(state), 32'd1);
      chk("start_pc0",      32'(bus.pc_f), 32'h000);
      chk("start_fetch_en", 32'(bus.fetch_en), 32'd1);
      chk("start_flush",    32'(bus.flush_ex), 32'd1);
      tick(1);
      chk("start_pc1",    32'(bus.pc_f), 32'h001);
      chk("start_flush0", 32'(bus.flush_ex), 32'd0);
      chk("start_ret0",   retired_cnt, 32'd0);
      tick(1);
      chk("start_pc2",  32'(bus.pc_f), 32'h002);
      chk("start_ret1", retired_cnt, 32'd1);
      tick(8);
      chk("pre_br_pc",  32'(bus.pc_f), 32'h00A);
      chk("pre_br_ret", retired_cnt, 32'd9);

      // Redirect at pc 0x00A to 0x040: one bubble, branch retires
      bus.branch_taken_ex  = 1'b1;
      bus.branch_target_ex = 12'h040;
      tick(1);
      bus.branch_taken_ex = 1'b0;
      chk("br_pc",     32'(bus.pc_f), 32'h040);
      chk("br_flush",  32'(bus.flush_ex), 32'd1);
      chk("br_ret",    retired_cnt, 32'd10);
      chk("br_state",  32'(state), 32'd1);
      tick(1);
      chk("br_pc1",    32'(bus.pc_f), 32'h041);
      chk("br_flush0", 32'(bus.flush_ex), 32'd0);
      chk("br_ret_b",  retired_cnt, 32'd10);
      tick(1);
      chk("br_ret2",   retired_cnt, 32'd11);

      // Forwarding selects
      bus.regwrite_wb = 1'b1; bus.rd_wb = 5'd5; bus.rs1_ex = 5'd5; bus.rs2_ex = 5'd5;
      #1;
      chk("fwd_a_hit", 32'(bus.fwd_a), 32'd1);
      chk("fwd_b_hit", 32'(bus.fwd_b), 32'd1);
      bus.rd_wb = 5'd0; bus.rs1_ex = 5'd0; bus.rs2_ex = 5'd0;
      #1;
      chk("fwd_a_x0", 32'(bus.fwd_a), 32'd0);
      chk("fwd_b_x0", 32'(bus.fwd_b), 32'd0);
      bus.rd_wb = 5'd5; bus.rs1_ex = 5'd5; bus.rs2_ex = 5'd6;
      #1;
      chk("fwd_a_only", 32'(bus.fwd_a), 32'd1);
      chk("fwd_b_miss", 32'(bus.fwd_b), 32'd0);
      bus.regwrite_wb = 1'b0;
      #1;
      chk("fwd_a_nowe", 32'(bus.fwd_a), 32'd0);
      bus.rd_wb = 5'd0; bus.rs1_ex = 5'd0; bus.rs2_ex = 5'd0;

      // Steer to pc 0x010 with a valid EX, then halt + branch together
      bus.branch_taken_ex  = 1'b1;
      bus.branch_target_ex = 12'h00F;
      tick(1);
      bus.branch_taken_ex = 1'b0;
      tick(1);
      chk("h_pre_pc",  32'(bus.pc_f), 32'h010);
      chk("h_pre_ret", retired_cnt, 32'd12);
      bus.halt_ex          = 1'b1;
      bus.branch_taken_ex  = 1'b1;
      bus.branch_target_ex = 12'h123;
      tick(1);
      bus.halt_ex         = 1'b0;
      bus.branch_taken_ex = 1'b0;
      chk("h_state",    32'(state), 32'd2);
      chk("h_pc",       32'(bus.pc_f), 32'h010);
      chk("h_ret",      retired_cnt, 32'd12);
      chk("h_fetch_en", 32'(bus.fetch_en), 32'd0);
      chk("h_flush",    32'(bus.flush_ex), 32'd1);
      tick(2);
      chk("h_hold_state", 32'(state), 32'd2);
      chk("h_hold_pc",    32'(bus.pc_f), 32'h010);
      run = 1'b0;
      tick(1);
      chk("h_run0_state", 32'(state), 32'd2);
      run = 1'b1;
      tick(1);
      chk("res_state", 32'(state), 32'd1);
      chk("res_pc",    32'(bus.pc_f), 32'h010);
      tick(1);
      chk("res_pc1",   32'(bus.pc_f), 32'h011);

      // Wrap 0xFFF -> 0x000
      bus.branch_taken_ex  = 1'b1;
      bus.branch_target_ex = 12'hFFF;
      tick(1);
      bus.branch_taken_ex = 1'b0;
      chk("wrap_pre", 32'(bus.pc_f), 32'hFFF);
      tick(1);
      chk("wrap_pc",  32'(bus.pc_f), 32'h000);
      chk("wrap_ret", retired_cnt, 32'd13);

      // Dropping run stops in HALT with pc held; EX instruction completes
      run = 1'b0;
      tick(1);
      chk("stop_state", 32'(state), 32'd2);
      chk("stop_pc",    32'(bus.pc_f), 32'h000);
      chk("stop_ret",   retired_cnt, 32'd14);
      tick(1);
      chk("stop_ret2",  retired_cnt, 32'd15);
      chk("stop_flush", 32'(bus.flush_ex), 32'd1);

      // Clear: back to IDLE, counter untouched
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      chk("clr_state", 32'(state), 32'd0);
      chk("clr_pc",    32'(bus.pc_f), 32'h000);
      chk("clr_ret",   retired_cnt, 32'd15);

      // Run up to a halt at pc 0x020
      run = 1'b1;
      tick(1);
      chk("rerun_state", 32'(state), 32'd1);
      tick(1);
      bus.branch_taken_ex  = 1'b1;
      bus.branch_target_ex = 12'h01F;
      tick(1);
      bus.branch_taken_ex = 1'b0;
      tick(1);
      bus.halt_ex = 1'b1;
      tick(1);
      bus.halt_ex = 1'b0;
      chk("s_pre_state", 32'(state), 32'd2);
      chk("s_pre_pc",    32'(bus.pc_f), 32'h020);
      chk("s_pre_ret",   retired_cnt, 32'd16);

      step_req = 1'b1;
      tick(1);
      step_req = 1'b0;
`ifdef PIPE_CTRL_SINGLE_STEP_EN
      chk("s_fetch_state", 32'(state), 32'd3);
      chk("s_fetch_en",    32'(bus.fetch_en), 32'd1);
      chk("s_fetch_pc",    32'(bus.pc_f), 32'h020);
      tick(1);
      chk("s_exec_state",  32'(state), 32'd3);
      chk("s_exec_en",     32'(bus.fetch_en), 32'd0);
      chk("s_exec_pc",     32'(bus.pc_f), 32'h021);
      chk("s_exec_flush",  32'(bus.flush_ex), 32'd0);
      tick(1);
      chk("s_done_state",  32'(state), 32'd2);
      chk("s_done_pc",     32'(bus.pc_f), 32'h021);
      chk("s_done_ret",    retired_cnt, 32'd17);
      chk("s_done_en",     32'(bus.fetch_en), 32'd0);
`else
      chk("nostep_state", 32'(state), 32'd2);
      chk("nostep_en",    32'(bus.fetch_en), 32'd0);
      tick(1);
      chk("nostep_pc",    32'(bus.pc_f), 32'h020);
      chk("nostep_ret",   retired_cnt, 32'd16);
`endif

      // Asynchronous reset in the middle of a redirect
      run = 1'b0;
      tick(1);
      run = 1'b1;
      tick(2);
      bus.branch_taken_ex  = 1'b1;
      bus.branch_target_ex = 12'h055;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_state", 32'(state), 32'd0);
      chk("arst_pc",    32'(bus.pc_f), 32'h000);
      chk("arst_flush", 32'(bus.flush_ex), 32'd1);
      chk("arst_ret",   retired_cnt, 32'd0);
      bus.branch_taken_ex = 1'b0;
      run = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(1);
      chk("post_state", 32'(state), 32'd0);
      chk("post_pc",    32'(bus.pc_f), 32'h000);
      run = 1'b1;
      tick(2);
      chk("post_pc1",   32'(bus.pc_f), 32'h001);
      chk("post_ret",   retired_cnt, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter PC_W, default 12: width of the word-indexed fetch address.
REQ-002 Parameter RESET_PC, default 0: fetch address loaded on reset and on clear.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 run  in  1  level; enables execution; 0->1 edge resumes from HALT.
REQ-006 clear  in  1  synchronous restart to IDLE with pc_f=RESET_PC.
REQ-007 branch_taken_ex  in  1  EX instruction redirects fetch.
REQ-008 branch_target_ex  in  PC_W  redirect address.
REQ-009 halt_ex  in  1  EX instruction is ebreak.
REQ-010 rs1_ex, rs2_ex  in  5 each  EX source register indices.
REQ-011 rd_wb  in  5  WB destination index; regwrite_wb  in  1  WB write enable.
REQ-012 step_req  in  1  single-step pulse (see Configuration).
REQ-013 pc_f  out  PC_W  fetch address to instruction RAM, registered.
REQ-014 fetch_en  out  1  capture the fetched word into the EX register this cycle.
REQ-015 flush_ex  out  1  EX instruction is a bubble; CPU suppresses regwrite and gpio_we.
REQ-016 fwd_a, fwd_b  out  1 each  select WB write data instead of regfile readdata1/readdata2.
REQ-017 state  out  2  IDLE=0, RUN=1, HALT=2, STEP=3.
REQ-018 retired_cnt  out  32  count of retired instructions.

Function
REQ-019 fetch_en SHALL be 1 in RUN and in the STEP fetch cycle, 0 otherwise (combinational from state).
REQ-020 Internal ex_valid register SHALL load fetch_en & ~redirect & ~halt, where redirect = ex_valid & branch_taken_ex and halt = ex_valid & halt_ex; flush_ex SHALL be ~ex_valid.
REQ-021 branch_taken_ex and halt_ex SHALL be ignored while ex_valid=0.
REQ-022 IDLE: pc_f holds; transition to RUN on the cycle after run=1 is sampled.
REQ-023 RUN: pc_f <= pc_f+1 each cycle, wrapping from 2^PC_W-1 to 0.
REQ-024 RUN with redirect: pc_f <= branch_target_ex; the word fetched in that cycle SHALL be squashed (one bubble); state remains RUN.
REQ-025 RUN with halt: pc_f holds; state -> HALT; halt takes priority over simultaneous redirect.
REQ-026 RUN with run=0 and no halt: state -> HALT; pc_f holds; a valid EX instruction completes normally.
REQ-027 HALT: fetch_en=0; transition to RUN only on a run 0->1 edge (registered run_q); steady run=1 SHALL NOT resume.
REQ-028 clear=1 SHALL force state IDLE, pc_f=RESET_PC, ex_valid=0 from any state on the next edge; it takes priority over all other events; retired_cnt is unaffected.
REQ-029 retired_cnt SHALL increment by 1 on each cycle with ex_valid=1 and halt=0; it wraps at 2^32.
REQ-030 fwd_a = regwrite_wb & (rd_wb!=0) & (rd_wb==rs1_ex); fwd_b likewise on rs2_ex; combinational, independent of state.

Reset
REQ-031 rst_n=0 SHALL immediately set state=IDLE, pc_f=RESET_PC, ex_valid=0 (flush_ex=1), run_q=0, retired_cnt=0, with step logic idle.
REQ-032 Reset assertion mid-redirect or mid-step SHALL abandon the operation with no residual effect after release.

Configuration
REQ-033 Macro PIPE_CTRL_SINGLE_STEP_EN: when defined, step_req=1 in HALT enters STEP; STEP performs one fetch cycle (fetch_en=1, pc_f+1), then one execute cycle (fetch_en=0), then returns to HALT; a halt or redirect in the execute cycle applies as in RUN, with state returning to HALT.
REQ-034 Without PIPE_CTRL_SINGLE_STEP_EN: step_req is present but ignored; state value 3 is never produced.

Verification
REQ-035 Reset, run=1 at cycle 2 -> state=RUN at cycle 3; pc_f 0,1,2,...; flush_ex=0 from cycle 4.
REQ-036 Redirect: branch_taken_ex=1 with ex_valid=1 and target=0x040 at pc_f=0x00A -> next pc_f=0x040, flush_ex=1 for exactly one cycle, retired_cnt +1.
REQ-037 Halt plus simultaneous branch at pc_f=0x010 -> state=HALT, pc_f stays 0x010; run held at 1 keeps HALT; run 0->1 -> RUN fetching 0x010.
REQ-038 Forwarding: regwrite_wb=1, rd_wb=5, rs1_ex=5, rs2_ex=5 -> fwd_a=fwd_b=1; rd_wb=0 -> both 0.
REQ-039 Wrap: PC_W=12, pc_f=0xFFF in RUN -> next pc_f=0x000.
REQ-040 With PIPE_CTRL_SINGLE_STEP_EN, HALT at pc_f=0x020, step_req pulse -> one fetch_en pulse, pc_f=0x021, retired_cnt +1, state back to HALT after 2 cycles.
